// File: rtl/grf_ctrl_pkg.sv
// Shared types and constants for the GRF write-port controller and its scoreboard.
package grf_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      we;
    reg_addr_t a3;
    data_t     wd;
    data_t     pc;
  } grf_wr_t;

  function automatic logic is_real_reg(input reg_addr_t a);
    return a != REG_ZERO;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Busy bits for registers waiting on an MD result, plus the decode hazard compares.
module grf_scoreboard
  import grf_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  input  logic      rd_chk,
  input  reg_addr_t rd_addr,
  output logic      hazard
);

  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy;

  // $0 has no storage so it can never look busy.
  assign busy = {busy_q, 1'b0};

  // A set outranks a clear of the same register in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_addr == REG_ADDR_W'(i))
          busy_q[i] <= 1'b1;
        else if (clr_en && clr_addr == REG_ADDR_W'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  assign hazard = busy[rs_addr] | busy[rt_addr] | (rd_chk & busy[rd_addr]);

endmodule

// File: rtl/grf_wb_ctrl.sv
// Arbitrates the single GRF write port between W-stage writeback and buffered MD
// results, and stalls decode on hazards against outstanding MD destinations.
module grf_wb_ctrl
  import grf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  input  logic        iss_wr,
  input  logic        iss_md,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        stall,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             hold_vld;
  reg_addr_t        hold_addr;
  data_t            hold_data;
  data_t            hold_pc;
  logic [CNT_W-1:0] starve_cnt;

  logic    wb_use;
  logic    drain;
  logic    accept;
  logic    keep;
  logic    starve;
  logic    hazard;
  logic    stall_int;
  logic    issue;
  grf_wr_t port;

  assign wb_use    = wb_we && is_real_reg(wb_addr);
  assign drain     = hold_vld && !wb_use;
  assign md_ready  = !hold_vld && reset;
  assign accept    = md_valid && md_ready;
  assign keep      = accept && is_real_reg(md_addr);
  assign starve    = (starve_cnt == CNT_MAX);
  assign stall_int = hazard || starve;
  assign stall     = stall_int && reset;
  assign issue     = iss_wr && iss_md && !stall_int && is_real_reg(iss_rd);

  grf_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue),
    .set_addr (iss_rd),
    .clr_en   (drain),
    .clr_addr (hold_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_chk   (iss_wr),
    .rd_addr  (iss_rd),
    .hazard   (hazard)
  );

  // Single-entry MD hold buffer; results for $0 are accepted and dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hold_vld <= 1'b0;
    else if (keep)
      hold_vld <= 1'b1;
    else if (drain)
      hold_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      hold_addr <= md_addr;
      hold_data <= md_data;
      hold_pc   <= md_pc;
    end
  end

  // Counts cycles the hold buffer loses the port; saturation forces a decode stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!hold_vld || drain)
      starve_cnt <= '0;
    else if (!starve)
      starve_cnt <= starve_cnt + 1'b1;
  end

  // Pipeline writeback passes straight through; W-stage timing cannot slip.
  always_comb begin
    port.we = reset && (wb_use || hold_vld);
    port.a3 = hold_addr;
    port.wd = hold_data;
    port.pc = hold_pc;
    if (wb_use) begin
      port.a3 = wb_addr;
      port.wd = wb_data;
      port.pc = wb_pc;
    end
  end

  assign grf_we = port.we;
  assign grf_a3 = port.a3;
  assign grf_wd = port.wd;
  assign grf_pc = port.pc;

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Randomized and directed checks of grf_wb_ctrl against a cycle-level reference model.
module tb_grf_wb_ctrl;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;
  logic        iss_wr;
  logic        iss_md;
  logic [4:0]  iss_rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        stall;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  grf_wb_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_pc    (wb_pc),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .md_pc    (md_pc),
    .iss_wr   (iss_wr),
    .iss_md   (iss_md),
    .iss_rd   (iss_rd),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .stall    (stall),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which registers await MD data, the pending MD result, and
  // how many consecutive cycles that result has been blocked by the pipeline.
  bit          m_busy [32];
  bit          m_hv;
  logic [4:0]  m_ha;
  logic [31:0] m_hd;
  logic [31:0] m_hp;
  int          m_blocked;
  bit          e_stall;
  bit          e_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_hv      = 1'b0;
    m_blocked = 0;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
    md_valid = 0; md_addr = 0; md_data = 0; md_pc = 0;
    iss_wr = 0; iss_md = 0; iss_rd = 0; rs_addr = 0; rt_addr = 0;
  endtask

  // Compare combinational outputs mid-cycle against the model.
  task automatic eval_cycle();
    bit pipe;
    @(negedge clk);
    #1;
    pipe    = wb_we && (wb_addr != 0);
    e_ready = !m_hv;
    e_stall = m_busy[rs_addr] || m_busy[rt_addr] || (iss_wr && m_busy[iss_rd]) ||
              (m_blocked >= STARVE_LIMIT);
    check_eq("md_ready", 32'(md_ready), 32'(e_ready));
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("grf_we", 32'(grf_we), 32'(pipe || m_hv));
    if (pipe) begin
      check_eq("wb_a3", 32'(grf_a3), 32'(wb_addr));
      check_eq("wb_wd", grf_wd, wb_data);
      check_eq("wb_pc", grf_pc, wb_pc);
    end else if (m_hv) begin
      check_eq("md_a3", 32'(grf_a3), 32'(m_ha));
      check_eq("md_wd", grf_wd, m_hd);
      check_eq("md_pc", grf_pc, m_hp);
    end
  endtask

  // Advance the model across the rising edge with the inputs of this cycle.
  task automatic commit_cycle();
    bit pipe;
    @(posedge clk);
    #1;
    pipe = wb_we && (wb_addr != 0);
    if (m_hv && !pipe) begin
      m_busy[m_ha] = 1'b0;
      m_hv         = 1'b0;
      m_blocked    = 0;
    end else if (m_hv) begin
      if (m_blocked < STARVE_LIMIT) m_blocked++;
    end else begin
      m_blocked = 0;
    end
    if (iss_wr && iss_md && !e_stall && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    if (md_valid && e_ready && md_addr != 0) begin
      m_hv = 1'b1;
      m_ha = md_addr;
      m_hd = md_data;
      m_hp = md_pc;
    end
  endtask

  task automatic cycle();
    eval_cycle();
    commit_cycle();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_eq("rst_md_ready", 32'(md_ready), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_grf_we", 32'(grf_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle();

    // Idle-port drain with a RAW consumer on rs.
    iss_wr = 1; iss_md = 1; iss_rd = 8;
    cycle();
    idle_inputs();
    md_valid = 1; md_addr = 8; md_data = 32'hDEADBEEF; md_pc = 32'h0000_1000;
    rs_addr = 8;
    eval_cycle();
    check_eq("raw_stall_accept", 32'(stall), 32'd1);
    commit_cycle();
    md_valid = 0;
    eval_cycle();
    check_eq("drain_we", 32'(grf_we), 32'd1);
    check_eq("drain_a3", 32'(grf_a3), 32'd8);
    check_eq("drain_wd", grf_wd, 32'hDEADBEEF);
    check_eq("raw_stall_drain", 32'(stall), 32'd1);
    commit_cycle();
    rt_addr = 0;
    eval_cycle();
    check_eq("raw_released", 32'(stall), 32'd0);
    check_eq("after_drain_we", 32'(grf_we), 32'd0);
    commit_cycle();

    // WAW against an outstanding MD destination, then an MD result to $0.
    idle_inputs();
    iss_wr = 1; iss_md = 1; iss_rd = 5;
    cycle();
    iss_md = 0;
    eval_cycle();
    check_eq("waw_stall", 32'(stall), 32'd1);
    commit_cycle();
    idle_inputs();
    md_valid = 1; md_addr = 0; md_data = 32'h1234_5678;
    eval_cycle();
    check_eq("zero_accept_ready", 32'(md_ready), 32'd1);
    commit_cycle();
    md_valid = 0;
    eval_cycle();
    check_eq("zero_ready_next", 32'(md_ready), 32'd1);
    check_eq("zero_no_write", 32'(grf_we), 32'd0);
    commit_cycle();

    // Port contention: pipeline writes every cycle while MD result for $9 waits.
    md_valid = 1; md_addr = 9; md_data = 32'hCAFE_0009; md_pc = 32'h0000_2000;
    wb_we = 1; wb_addr = 3; wb_data = 32'h3333_0000; wb_pc = 32'h0000_3000;
    cycle();
    md_valid = 0;
    for (int i = 0; i < 10; i++) begin
      wb_data = 32'h3333_0000 + 32'(i);
      eval_cycle();
      check_eq("cont_a3", 32'(grf_a3), 32'd3);
      check_eq("cont_starve", 32'(stall), 32'(i >= STARVE_LIMIT));
      commit_cycle();
    end
    wb_we = 0;
    eval_cycle();
    check_eq("cont_drain_a3", 32'(grf_a3), 32'd9);
    check_eq("cont_drain_wd", grf_wd, 32'hCAFE_0009);
    commit_cycle();
    eval_cycle();
    check_eq("cont_stall_clear", 32'(stall), 32'd0);
    commit_cycle();

    // Asynchronous reset with a blocked MD result and busy[8] set.
    idle_inputs();
    iss_wr = 1; iss_md = 1; iss_rd = 8;
    cycle();
    idle_inputs();
    md_valid = 1; md_addr = 8; md_data = 32'h0808_0808;
    wb_we = 1; wb_addr = 3;
    cycle();
    md_valid = 0; rs_addr = 8;
    eval_cycle();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(grf_we), 32'd0);
    check_eq("mid_rst_ready", 32'(md_ready), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    wb_we = 0;
    eval_cycle();
    check_eq("post_rst_ready", 32'(md_ready), 32'd1);
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_we", 32'(grf_we), 32'd0);
    commit_cycle();

    // Random traffic over a small register window to provoke hazards and contention.
    for (int n = 0; n < 600; n++) begin
      wb_we    = ($urandom_range(0, 9) < 6);
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      wb_pc    = $urandom;
      md_valid = ($urandom_range(0, 1) == 1);
      md_addr  = 5'($urandom_range(0, 7));
      md_data  = $urandom;
      md_pc    = $urandom;
      iss_wr   = ($urandom_range(0, 1) == 1);
      iss_md   = ($urandom_range(0, 1) == 1);
      iss_rd   = 5'($urandom_range(0, 7));
      rs_addr  = 5'($urandom_range(0, 7));
      rt_addr  = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
